// File: rtl/duty_clk_ctrl.sv
// Programmable duty-cycle clock generator. The config handshake feeds an
// iterative divider that computes the high time. The result is shadow-buffered
// and only applied at a period boundary, so clk_out never glitches.
module duty_clk_ctrl #(
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned PERIOD = 4,
    parameter int unsigned DUTY   = 50
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [6:0]       cfg_duty,
    output logic             cfg_err,
    output logic             clk_out,
    output logic             period_tick,
    output logic             running
);

    localparam int unsigned PW = CNT_W + 7;       // product / dividend width
    localparam int unsigned SW = $clog2(PW);      // divide step counter width
    localparam logic [CNT_W-1:0] PERIOD0 = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0] HIGH0   = CNT_W'(PERIOD * DUTY / 100);

    typedef enum logic {StIdle, StRun} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] act_period, act_high;
    logic             pend_valid;
    logic [CNT_W-1:0] pend_period, pend_high;

    logic             busy;
    logic [SW-1:0]    step;
    logic [6:0]       rem;
    logic [PW-1:0]    quo;
    logic [CNT_W-1:0] calc_period;

    logic [7:0]       trial;
    logic [6:0]       rem_nxt;
    logic [PW-1:0]    quo_nxt;
    logic             calc_done;
    logic [CNT_W-1:0] calc_high;
    logic             cfg_take, cfg_bad;
    logic [CNT_W-1:0] idle_period, idle_high, bnd_high;
    logic             at_boundary;

    // One restoring-division step: dividend shifts out of quo, quotient shifts in
    always_comb begin
        trial = {rem, quo[PW-1]};
        if (trial >= 8'd100) begin
            rem_nxt = 7'(trial - 8'd100);
            quo_nxt = {quo[PW-2:0], 1'b1};
        end else begin
            rem_nxt = trial[6:0];
            quo_nxt = {quo[PW-2:0], 1'b0};
        end
    end

    assign calc_done   = busy && (step == SW'(PW - 1));
    assign calc_high   = quo_nxt[CNT_W-1:0];
    assign cfg_ready   = !busy && !pend_valid;
    assign cfg_take    = cfg_valid && cfg_ready;
    assign cfg_bad     = (cfg_period < CNT_W'(2)) || (cfg_duty > 7'd100);
    assign at_boundary = (cnt == act_period - CNT_W'(1));

    // Config that takes effect on the next IDLE edge (a finishing divide wins)
    always_comb begin
        idle_period = act_period;
        idle_high   = act_high;
        if (calc_done) begin
            idle_period = calc_period;
            idle_high   = calc_high;
        end else if (pend_valid) begin
            idle_period = pend_period;
            idle_high   = pend_high;
        end
        bnd_high = pend_valid ? pend_high : act_high;
    end

    // Config handshake and iterative divider
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy        <= 1'b0;
            step        <= '0;
            rem         <= '0;
            quo         <= '0;
            calc_period <= '0;
            cfg_err     <= 1'b0;
        end else begin
            cfg_err <= cfg_take && cfg_bad;
            if (cfg_take && !cfg_bad) begin
                busy        <= 1'b1;
                step        <= '0;
                rem         <= '0;
                quo         <= {7'b0, cfg_period} * {{CNT_W{1'b0}}, cfg_duty};
                calc_period <= cfg_period;
            end else if (busy) begin
                rem  <= rem_nxt;
                quo  <= quo_nxt;
                step <= step + SW'(1);
                if (calc_done) begin
                    busy <= 1'b0;
                end
            end
        end
    end

    // Run FSM, period counter, shadow apply and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= StIdle;
            cnt         <= '0;
            act_period  <= PERIOD0;
            act_high    <= HIGH0;
            pend_valid  <= 1'b0;
            pend_period <= '0;
            pend_high   <= '0;
            clk_out     <= 1'b0;
            period_tick <= 1'b0;
            running     <= 1'b0;
        end else begin
            period_tick <= 1'b0;
            unique case (state)
                StIdle: begin
                    cnt        <= '0;
                    clk_out    <= 1'b0;
                    running    <= 1'b0;
                    act_period <= idle_period;
                    act_high   <= idle_high;
                    pend_valid <= 1'b0;
                    if (enable) begin
                        state   <= StRun;
                        running <= 1'b1;
                        clk_out <= (idle_high != '0);
                    end
                end
                StRun: begin
                    if (at_boundary) begin
                        period_tick <= 1'b1;
                        cnt         <= '0;
                        if (!enable) begin
                            state   <= StIdle;
                            clk_out <= 1'b0;
                            running <= 1'b0;
                        end else begin
                            if (pend_valid) begin
                                act_period <= pend_period;
                                act_high   <= pend_high;
                                pend_valid <= 1'b0;
                            end
                            clk_out <= (bnd_high != '0);
                        end
                    end else begin
                        cnt     <= cnt + CNT_W'(1);
                        clk_out <= ((cnt + CNT_W'(1)) < act_high);
                    end
                    // A divide finishing during RUN waits for the next boundary
                    if (calc_done) begin
                        pend_valid  <= 1'b1;
                        pend_period <= calc_period;
                        pend_high   <= calc_high;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_duty_clk_ctrl.sv
// Bench for duty_clk_ctrl: directed steps plus random traffic, every cycle
// compared against a behavioural model of the generated waveform.
module tb_duty_clk_ctrl;

    localparam int unsigned CNT_W = 8;
    localparam int CALC_CYC = CNT_W + 7;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             enable = 1'b0;
    logic             cfg_valid = 1'b0;
    logic [CNT_W-1:0] cfg_period = '0;
    logic [6:0]       cfg_duty = '0;
    logic             cfg_ready, cfg_err, clk_out, period_tick, running;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;
    int cyc = 0;

    // Model state: position within the running period and the active/pending config
    bit m_run, m_busy, m_pv, m_err, m_tick, m_took;
    int m_pos, m_per, m_high, m_left, m_cp, m_ch, m_pp, m_ph;

    always #5 clk = ~clk;

    duty_clk_ctrl #(.CNT_W(CNT_W), .PERIOD(4), .DUTY(50)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_period (cfg_period),
        .cfg_duty   (cfg_duty),
        .cfg_err    (cfg_err),
        .clk_out    (clk_out),
        .period_tick(period_tick),
        .running    (running)
    );

    function automatic void model_reset();
        m_run = 0; m_busy = 0; m_pv = 0; m_err = 0; m_tick = 0; m_took = 0;
        m_pos = 0; m_per = 4; m_high = 4 * 50 / 100; m_left = 0;
        m_cp = 0; m_ch = 0; m_pp = 0; m_ph = 0;
    endfunction

    // Advance the model by one clock edge using the inputs seen at that edge
    function automatic void model_step();
        bit ready, take, bad, done;
        ready  = !m_busy && !m_pv;
        take   = cfg_valid && ready;
        bad    = (int'(cfg_period) < 2) || (int'(cfg_duty) > 100);
        done   = m_busy && (m_left == 1);
        m_took = take;
        m_err  = take && bad;
        m_tick = 0;
        if (take && !bad) begin
            m_busy = 1;
            m_left = CALC_CYC;
            m_cp   = int'(cfg_period);
            m_ch   = int'(cfg_period) * int'(cfg_duty) / 100;
        end else if (m_busy) begin
            m_left--;
            m_busy = (m_left != 0);
        end
        if (!m_run) begin
            if (done) begin
                m_per = m_cp; m_high = m_ch;
            end else if (m_pv) begin
                m_per = m_pp; m_high = m_ph; m_pv = 0;
            end
            if (enable) begin
                m_run = 1; m_pos = 0;
            end
        end else begin
            if (m_pos == m_per - 1) begin
                m_tick = 1;
                m_pos  = 0;
                if (!enable) m_run = 0;
                else if (m_pv) begin
                    m_per = m_pp; m_high = m_ph; m_pv = 0;
                end
            end else begin
                m_pos++;
            end
            if (done) begin
                m_pv = 1; m_pp = m_cp; m_ph = m_ch;
            end
        end
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %b, expected %b", tag, cyc, obs, exp);
        end
    endtask

    task automatic compare_all();
        chk("clk_out", clk_out, m_run && (m_pos < m_high));
        chk("period_tick", period_tick, m_tick);
        chk("running", running, m_run);
        chk("cfg_ready", cfg_ready, !m_busy && !m_pv);
        chk("cfg_err", cfg_err, m_err);
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        if (!rst_n) model_reset();
        else model_step();
        #1 compare_all();
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Offer a config and hold it until accepted, like a well-behaved source
    task automatic offer(input int p, input int d);
        int n = 0;
        cfg_valid  = 1'b1;
        cfg_period = CNT_W'(p);
        cfg_duty   = 7'(d);
        do begin
            tick();
            n++;
        end while (!m_took && n < 400);
        cfg_valid = 1'b0;
        if (!m_took) begin
            n_total++;
            n_fail++;
            $error("FAIL offer_timeout: observed not accepted, expected accepted within 400 cycles");
        end
    endtask

    // Asynchronous reset placed between clock edges, checked before the next edge
    task automatic async_reset();
        enable    = 1'b0;
        cfg_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 model_reset();
        compare_all();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        // Power-on reset
        #3 model_reset();
        compare_all();
        tick();
        tick();
        rst_n = 1'b1;
        cycles(2);

        // Defaults: period 4, 2 high / 2 low
        enable = 1'b1;
        cycles(20);

        // Reconfigure in IDLE, then run at period 10 duty 25
        enable = 1'b0;
        cycles(6);
        offer(10, 25);
        cycles(20);
        enable = 1'b1;
        cycles(30);

        // Reconfigure while running: applies at the next boundary
        offer(10, 75);
        cycles(40);

        // Duty extremes, then rejected offers
        offer(8, 0);
        cycles(40);
        offer(8, 100);
        cycles(40);
        offer(1, 50);
        cycles(5);
        offer(8, 101);
        cycles(20);

        // Drop enable early in a 10-cycle period
        offer(10, 25);
        cycles(40);
        n = 0;
        while (!(m_run && m_pos == 1) && n < 100) begin
            tick();
            n++;
        end
        enable = 1'b0;
        cycles(15);
        enable = 1'b1;
        cycles(25);

        // Reset in the middle of a divide
        offer(20, 33);
        cycles(5);
        async_reset();
        enable = 1'b1;
        cycles(20);

        // Reset in the middle of a running period
        cycles(7);
        async_reset();
        enable = 1'b1;
        cycles(20);

        // Random enable and config traffic, including invalid offers
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) enable = ~enable;
            if (cfg_valid && m_took) begin
                cfg_valid = 1'b0;
            end else if (!cfg_valid && $urandom_range(0, 9) == 0) begin
                cfg_valid  = 1'b1;
                cfg_period = CNT_W'($urandom_range(0, 24));
                cfg_duty   = 7'($urandom_range(0, 110));
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
